pll_lock_monitor: RTL and testbench
===================================

PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for lock_in, range 2..4.
REQ-002 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock-high cycles required before reset release, minimum 2.
REQ-003 SHALL have parameter GLITCH_CYCLES, default 4: consecutive synchronized-lock-low cycles in RUN that count as lock loss, minimum 1.
REQ-004 SHALL have parameter HOLD_CYCLES, default 16: minimum cycles spent in LOST before re-qualifying, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, the PLL output clock domain.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port lock_in, input, 1 bit: raw PLL lock, asynchronous to clk.
REQ-008 SHALL have port clr_cnt, input, 1 bit: synchronous clear of loss_cnt.
REQ-009 SHALL have port rst_out_n, output, 1 bit: registered active-low reset to downstream logic.
REQ-010 SHALL have port ready, output, 1 bit: high only in RUN.
REQ-011 SHALL have port loss_pulse, output, 1 bit: one-cycle strobe on each detected lock loss.
REQ-012 SHALL have port loss_cnt, output, 8 bits: saturating count of lock-loss events.
REQ-013 SHALL have port state_o, output, 2 bits: current FSM state encoding.

Function
REQ-014 SHALL pass lock_in through a SYNC_STAGES flop chain; lock_s is the last stage, and the FSM uses lock_s only.
REQ-015 SHALL implement FSM states WAIT_LOCK=0, STABLE=1, RUN=2, LOST=3.
REQ-016 WAIT_LOCK SHALL go to STABLE on lock_s=1 and clear the stability counter.
REQ-017 STABLE SHALL increment the counter while lock_s=1.
REQ-018 STABLE SHALL return to WAIT_LOCK on any lock_s=0 cycle.
REQ-019 STABLE SHALL go to RUN when the counter reaches STABLE_CYCLES-1 with lock_s=1.
REQ-020 RUN SHALL count consecutive lock_s=0 cycles and reset that count on lock_s=1.
REQ-021 RUN SHALL go to LOST when the low count reaches GLITCH_CYCLES.
REQ-022 LOST SHALL hold for HOLD_CYCLES cycles regardless of lock_s, then go to WAIT_LOCK.
REQ-023 rst_out_n and ready SHALL be registered: 1 from the first RUN cycle, and 0 from the first LOST cycle.
REQ-024 loss_pulse SHALL be high exactly in the first LOST cycle.
REQ-025 loss_cnt SHALL increment on the same edge that enters LOST, and SHALL saturate at 255.
REQ-026 On clr_cnt alone, loss_cnt SHALL become 0 on the next edge.
REQ-027 When clr_cnt and a loss-entry coincide, loss_cnt SHALL become 1.
REQ-028 Minimum latency from lock_in rising to rst_out_n rising SHALL be SYNC_STAGES+STABLE_CYCLES+1 cycles (lock_in sampled stable).
REQ-029 Counter widths SHALL be $clog2 of the respective parameter plus 1; no counter SHALL wrap.
REQ-030 GLITCH_CYCLES=1 SHALL enter LOST on the first lock_s=0 cycle in RUN.

Reset
REQ-031 rst_n low SHALL asynchronously set state=WAIT_LOCK and all synchronizer stages, counters and loss_cnt to 0.
REQ-032 rst_n low SHALL asynchronously set rst_out_n=0, ready=0 and loss_pulse=0.
REQ-033 Deassertion of rst_n SHALL be consumed synchronously: the first FSM transition occurs no earlier than the second clk edge after release.
REQ-034 rst_n asserted mid-STABLE or mid-RUN SHALL discard all progress, and re-qualification SHALL restart from WAIT_LOCK.

Structure
REQ-035 A shared package SHALL hold the state enum/localparams (WAIT_LOCK..LOST) and the loss_cnt width constant (8).
REQ-036 The synchronizer SHALL be the single sub-module sync_ff (parameter STAGES, async active-low reset to 0); all else SHALL be in pll_lock_monitor.

Verification
REQ-037 With params 2/8/4/16: hold lock_in=1 from reset release -> rst_out_n rises exactly 11 cycles after the first edge sampling lock_in=1; loss_pulse=0; loss_cnt=0.
REQ-038 In STABLE at count 5, drop lock_in for 1 cycle -> state returns to WAIT_LOCK; the full 8-cycle qualification restarts; no loss_pulse.
REQ-039 In RUN, drop lock_in for 3 cycles -> no LOST, and rst_out_n stays 1; drop it for 4 cycles -> LOST, rst_out_n=0, one loss_pulse, loss_cnt=1, LOST held 16 cycles.
REQ-040 Force 260 loss events -> loss_cnt saturates at 255; clr_cnt coincident with the 261st loss entry -> loss_cnt=1.
REQ-041 Assert rst_n mid-RUN with lock_in=1 -> outputs are 0 immediately (asynchronously); after release, re-qualification takes the full 11 cycles.

Source files
------------

// File: rtl/pll_lock_monitor_pkg.sv
// PLL lock monitor shared types.
// State encoding and loss counter sizing.
package pll_lock_monitor_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } state_t;

  localparam int LOSS_CNT_W = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

endpackage

// File: rtl/pll_lock_monitor_sync_ff.sv
// Multi-flop synchronizer for the raw PLL lock.
// Cleared to 0 so the monitor starts out unlocked.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_monitor.sv
// Qualifies PLL lock before releasing downstream reset,
// and detects and counts loss of lock while running.
module pll_lock_monitor
  import pll_lock_monitor_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int GLITCH_CYCLES = 4,
  parameter int HOLD_CYCLES   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lock_in,
  input  logic                  clr_cnt,
  output logic                  rst_out_n,
  output logic                  ready,
  output logic                  loss_pulse,
  output logic [LOSS_CNT_W-1:0] loss_cnt,
  output logic [1:0]            state_o
);

  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam int GW = $clog2(GLITCH_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;

  localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [GW-1:0] LOW_LAST = GW'(GLITCH_CYCLES - 1);
  localparam logic [HW-1:0] HLD_LAST = HW'(HOLD_CYCLES - 1);

  logic lock_s;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (lock_in),
    .q     (lock_s)
  );

  state_t                  state_q, state_d;
  logic [SW-1:0]           stb_q, stb_d;
  logic [GW-1:0]           low_q, low_d;
  logic [HW-1:0]           hld_q, hld_d;
  logic [LOSS_CNT_W-1:0]   cnt_d;
  logic                    loss_entry;

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    low_d   = low_q;
    hld_d   = hld_q;
    unique case (state_q)
      WAIT_LOCK: begin
        stb_d = '0;
        if (lock_s) state_d = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (stb_q == STB_LAST) begin
          state_d = RUN;
          low_d   = '0;
        end else begin
          stb_d = stb_q + 1'b1;
        end
      end
      RUN: begin
        if (lock_s) begin
          low_d = '0;
        end else if (low_q == LOW_LAST) begin
          state_d = LOST;
          hld_d   = '0;
        end else begin
          low_d = low_q + 1'b1;
        end
      end
      LOST: begin
        if (hld_q == HLD_LAST) state_d = WAIT_LOCK;
        else                   hld_d   = hld_q + 1'b1;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  assign loss_entry = (state_q == RUN) && (state_d == LOST);

  // A loss on the clearing edge still counts as the first event.
  always_comb begin
    cnt_d = loss_cnt;
    if (loss_entry) begin
      if (clr_cnt)                      cnt_d = LOSS_CNT_W'(1);
      else if (loss_cnt != LOSS_CNT_MAX) cnt_d = loss_cnt + 1'b1;
    end else if (clr_cnt) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_LOCK;
      stb_q      <= '0;
      low_q      <= '0;
      hld_q      <= '0;
      rst_out_n  <= 1'b0;
      ready      <= 1'b0;
      loss_pulse <= 1'b0;
      loss_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      low_q      <= low_d;
      hld_q      <= hld_d;
      rst_out_n  <= (state_d == RUN);
      ready      <= (state_d == RUN);
      loss_pulse <= loss_entry;
      loss_cnt   <= cnt_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor (2/8/4/16).
// Expected values are queued at stimulus and popped at sample.
module tb_pll_lock_monitor;
  import pll_lock_monitor_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       lock_in;
  logic       clr_cnt;
  logic       rst_out_n;
  logic       ready;
  logic       loss_pulse;
  logic [7:0] loss_cnt;
  logic [1:0] state_o;

  pll_lock_monitor #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (8),
    .GLITCH_CYCLES (4),
    .HOLD_CYCLES   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lock_in    (lock_in),
    .clr_cnt    (clr_cnt),
    .rst_out_n  (rst_out_n),
    .ready      (ready),
    .loss_pulse (loss_pulse),
    .loss_cnt   (loss_cnt),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_fail;
  int   model_cnt;

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [15:0] obs);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=%0h required=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rst(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (rst_out_n !== 1'b1 && n < budget);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget,
                            output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (state_o !== s && n < budget);
  endtask

  task automatic chk_all_zero(input string pfx);
    push({pfx, "_rst_out_n"}, 16'd0);
    pop_chk(16'(rst_out_n));
    push({pfx, "_ready"}, 16'd0);
    pop_chk(16'(ready));
    push({pfx, "_loss_pulse"}, 16'd0);
    pop_chk(16'(loss_pulse));
    push({pfx, "_loss_cnt"}, 16'd0);
    pop_chk(16'(loss_cnt));
    push({pfx, "_state"}, 16'(WAIT_LOCK));
    pop_chk(16'(state_o));
  endtask

  initial begin
    int n;
    n_chk     = 0;
    n_fail    = 0;
    model_cnt = 0;
    rst_n     = 1'b0;
    lock_in   = 1'b0;
    clr_cnt   = 1'b0;
    #2;
    chk_all_zero("reset");
    repeat (3) step();

    // lock held from release: 11 edges incl. the first sampling one
    push("lat_release", 16'd11);
    rst_n   = 1'b1;
    lock_in = 1'b1;
    wait_rst(30, n);
    pop_chk(16'(n));
    push("lat_ready", 16'd1);
    pop_chk(16'(ready));
    push("lat_pulse", 16'd0);
    pop_chk(16'(loss_pulse));
    push("lat_cnt", 16'd0);
    pop_chk(16'(loss_cnt));

    // 3-cycle dropout is filtered
    lock_in = 1'b0;
    repeat (3) step();
    lock_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push("glitch3_rst_out_n", 16'd1);
      step();
      pop_chk(16'(rst_out_n));
    end
    push("glitch3_state", 16'(RUN));
    pop_chk(16'(state_o));

    // 4-cycle dropout is a loss
    push("loss_latency", 16'd6);
    lock_in = 1'b0;
    repeat (4) step();
    lock_in = 1'b1;
    n = 4;
    while (loss_pulse !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    pop_chk(16'(n));
    model_cnt = 1;
    push("loss_rst_out_n", 16'd0);
    pop_chk(16'(rst_out_n));
    push("loss_ready", 16'd0);
    pop_chk(16'(ready));
    push("loss_cnt1", 16'(model_cnt));
    pop_chk(16'(loss_cnt));
    push("loss_state", 16'(LOST));
    pop_chk(16'(state_o));
    push("loss_pulse_width", 16'd0);
    push("lost_hold", 16'd16);
    n = 1;
    step();
    pop_chk(16'(loss_pulse));
    while (state_o === 2'(LOST) && n < 40) begin
      n++;
      step();
    end
    pop_chk(16'(n));
    push("lost_exit_state", 16'(WAIT_LOCK));
    pop_chk(16'(state_o));
    push("requal_after_lost", 16'd9);
    wait_rst(40, n);
    pop_chk(16'(n));

    // async reset mid-RUN
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_cnt = 0;
    step();
    push("lat_after_rst", 16'd11);
    rst_n = 1'b1;
    wait_rst(30, n);
    pop_chk(16'(n));

    // STABLE interrupted at count 5
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    push("to_stable", 16'd3);
    wait_state(2'(STABLE), 10, n);
    pop_chk(16'(n));
    repeat (3) step();
    lock_in = 1'b0;
    step();
    lock_in = 1'b1;
    step();
    push("stable_cnt5_state", 16'(STABLE));
    pop_chk(16'(state_o));
    step();
    push("stable_drop_state", 16'(WAIT_LOCK));
    pop_chk(16'(state_o));
    push("stable_requal", 16'd9);
    wait_rst(30, n);
    pop_chk(16'(n));
    push("stable_pulse", 16'd0);
    pop_chk(16'(loss_pulse));
    push("stable_cnt", 16'd0);
    pop_chk(16'(loss_cnt));

    // 260 losses: saturation at 255
    for (int i = 1; i <= 260; i++) begin
      push("sat_lost", 16'(LOST));
      lock_in = 1'b0;
      repeat (6) step();
      pop_chk(16'(state_o));
      if (model_cnt < 255) model_cnt++;
      push("sat_cnt", 16'(model_cnt));
      pop_chk(16'(loss_cnt));
      push("sat_rerun", 16'd25);
      lock_in = 1'b1;
      wait_state(2'(RUN), 60, n);
      pop_chk(16'(n));
    end

    // clear coincident with loss entry
    lock_in = 1'b0;
    repeat (5) step();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    push("clr_loss_state", 16'(LOST));
    pop_chk(16'(state_o));
    push("clr_loss_cnt", 16'd1);
    pop_chk(16'(loss_cnt));

    // clear alone
    step();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    push("clr_only_cnt", 16'd0);
    pop_chk(16'(loss_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
